// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR generator/checker pair: state encoding and
// the feedback function both ends must agree on.
package lfsr_pkg;

    typedef logic [1:0] state_t;

    localparam state_t HUNT   = 2'd0;
    localparam state_t VERIFY = 2'd1;
    localparam state_t LOCKED = 2'd2;

    // Widest LFSR the shared feedback function accepts; callers zero-extend.
    localparam int MAX_W = 32;

    function automatic logic lfsr_feedback(input logic [MAX_W-1:0] shreg,
                                           input logic [MAX_W-1:0] taps);
        return ^(shreg & taps);
    endfunction

endpackage

// File: rtl/lfsr_checker_if.sv
// Receive-side bundle of the PRBS checker: serial bit in, lock/error status out.
interface lfsr_checker_if #(
    parameter int WIDTH = 3,
    parameter int ERR_W = 16
) ();
    logic             enable;
    logic             rx_bit;
    logic [WIDTH-1:0] config_taps;
    logic             clear_errors;
    logic             locked;
    logic             bit_error;
    logic [ERR_W-1:0] error_count;
    logic [1:0]       state;

    modport master (
        output enable, rx_bit, config_taps, clear_errors,
        input  locked, bit_error, error_count, state
    );

    modport slave (
        input  enable, rx_bit, config_taps, clear_errors,
        output locked, bit_error, error_count, state
    );
endinterface

// File: rtl/lfsr_err_counter.sv
// Saturating error counter; a clear in the same cycle as an increment wins.
module lfsr_err_counter #(
    parameter int ERR_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [ERR_W-1:0] count
);

    logic [ERR_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/lfsr_checker.sv
// Self-synchronising serial PRBS checker: hunts for the generator state, verifies
// it over LOCK_COUNT bits, then free-runs a local reference and counts bit errors.
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int WIDTH      = 3,
    parameter int LOCK_COUNT = 8,
    parameter int MISS_LIMIT = 4,
    parameter int ERR_W      = 16
) (
    input  logic          clk,
    input  logic          reset,
    lfsr_checker_if.slave bus
);

    localparam int FILL_W  = $clog2(WIDTH + 1);
    localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
    localparam int MISS_W  = $clog2(MISS_LIMIT + 1);

    localparam logic [FILL_W-1:0]  FILL_LAST  = FILL_W'(WIDTH - 1);
    localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_COUNT - 1);
    localparam logic [MISS_W-1:0]  MISS_LAST  = MISS_W'(MISS_LIMIT - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [WIDTH-1:0]   taps_q, taps_d;
    logic [FILL_W-1:0]  fill_cnt_q, fill_cnt_d;
    logic [MATCH_W-1:0] match_cnt_q, match_cnt_d;
    logic [MISS_W-1:0]  miss_cnt_q, miss_cnt_d;
    logic               locked_q, locked_d;
    logic               bit_error_q, bit_error_d;
    logic               err_inc;
    logic               pred;

    assign pred = lfsr_feedback(MAX_W'(shreg_q), MAX_W'(taps_q));

    // A tap change invalidates whatever we synchronised to, so it pre-empts the
    // bit compare. Once locked, the prediction (not rx_bit) is shifted back in
    // so a single channel error does not corrupt the reference.
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        taps_d      = bus.config_taps;
        fill_cnt_d  = fill_cnt_q;
        match_cnt_d = match_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        locked_d    = locked_q;
        bit_error_d = 1'b0;
        err_inc     = 1'b0;

        if ((state_q != HUNT) && (bus.config_taps != taps_q)) begin
            state_d    = HUNT;
            fill_cnt_d = '0;
            locked_d   = 1'b0;
        end else if (bus.enable) begin
            case (state_q)
                HUNT: begin
                    shreg_d = {shreg_q[WIDTH-2:0], bus.rx_bit};
                    if (fill_cnt_q == FILL_LAST) begin
                        state_d     = VERIFY;
                        fill_cnt_d  = '0;
                        match_cnt_d = '0;
                    end else begin
                        fill_cnt_d = fill_cnt_q + 1'b1;
                    end
                end
                VERIFY: begin
                    if (shreg_q == '0) begin
                        state_d    = HUNT;
                        fill_cnt_d = '0;
                    end else begin
                        shreg_d = {shreg_q[WIDTH-2:0], bus.rx_bit};
                        if (bus.rx_bit == pred) begin
                            if (match_cnt_q == MATCH_LAST) begin
                                state_d    = LOCKED;
                                miss_cnt_d = '0;
                                locked_d   = 1'b1;
                            end else begin
                                match_cnt_d = match_cnt_q + 1'b1;
                            end
                        end else begin
                            match_cnt_d = '0;
                        end
                    end
                end
                LOCKED: begin
                    shreg_d = {shreg_q[WIDTH-2:0], pred};
                    if (bus.rx_bit != pred) begin
                        bit_error_d = 1'b1;
                        err_inc     = 1'b1;
                        if (miss_cnt_q == MISS_LAST) begin
                            state_d    = HUNT;
                            fill_cnt_d = '0;
                            locked_d   = 1'b0;
                        end else begin
                            miss_cnt_d = miss_cnt_q + 1'b1;
                        end
                    end else begin
                        miss_cnt_d = '0;
                    end
                end
                default: begin
                    state_d    = HUNT;
                    fill_cnt_d = '0;
                    locked_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= HUNT;
            shreg_q     <= '0;
            taps_q      <= '0;
            fill_cnt_q  <= '0;
            match_cnt_q <= '0;
            miss_cnt_q  <= '0;
            locked_q    <= 1'b0;
            bit_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            taps_q      <= taps_d;
            fill_cnt_q  <= fill_cnt_d;
            match_cnt_q <= match_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            locked_q    <= locked_d;
            bit_error_q <= bit_error_d;
        end
    end

    lfsr_err_counter #(
        .ERR_W (ERR_W)
    ) u_err_counter (
        .clk   (clk),
        .reset (reset),
        .clear (bus.clear_errors),
        .inc   (err_inc),
        .count (bus.error_count)
    );

    assign bus.locked    = locked_q;
    assign bus.bit_error = bit_error_q;
    assign bus.state     = state_q;

endmodule
